// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage core.
// Tracks in-flight destination registers in a shadow pipeline (EX, MEM, WB)
// and produces PC/IF-ID stall, ID-EX bubble, IF-ID flush and halt-drain
// sequencing. Optional feature macro: HAZARD_FORWARDING_EN (when defined,
// only load-use hazards stall and EX operand forwarding selects are produced).
module hazard_ctrl #(
    parameter int unsigned REG_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IdValid,
    input  logic [REG_BITS-1:0] Rs,
    input  logic [REG_BITS-1:0] Rt,
    input  logic                RsValid,
    input  logic                RtValid,
    input  logic [REG_BITS-1:0] WriteReg,
    input  logic                RegWrEn,
    input  logic                MemRead,
    input  logic                Halt,
    input  logic                BranchTaken,
    output logic                Stall,
    output logic                IdExBubble,
    output logic                FlushIfId,
    output logic                Halted,
    output logic [1:0]          FwdA,
    output logic [1:0]          FwdB
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // One shadow-pipeline entry: valid, destination register, is-load
    typedef struct packed {
        logic                v;
        logic [REG_BITS-1:0] rd;
        logic                ld;
    } slot_t;

    state_t state;
    state_t state_next;
    slot_t  ex_s;
    slot_t  mem_s;
    slot_t  wb_s;
    slot_t  ex_next;

    logic stall_c;
    logic bubble_c;
    logic flush_c;
    logic advance_c;
    logic hazard_c;

    logic rs_ex;
    logic rt_ex;
    logic rs_mem;
    logic rt_mem;
    logic match_ex;
    logic match_mem;

    // Source-vs-slot comparisons; WB never hazards thanks to the bypassing regfile
    assign rs_ex     = RsValid & ex_s.v  & (Rs == ex_s.rd);
    assign rt_ex     = RtValid & ex_s.v  & (Rt == ex_s.rd);
    assign rs_mem    = RsValid & mem_s.v & (Rs == mem_s.rd);
    assign rt_mem    = RtValid & mem_s.v & (Rt == mem_s.rd);
    assign match_ex  = rs_ex | rt_ex;
    assign match_mem = rs_mem | rt_mem;

`ifdef HAZARD_FORWARDING_EN
    // With forwarding only a load result still in EX cannot be bypassed in time
    assign hazard_c = IdValid & ex_s.v & ex_s.ld & match_ex;
`else
    // Without forwarding any pending write in EX or MEM must retire first
    assign hazard_c = IdValid & (match_ex | match_mem);
`endif

    // Control outputs and next state; a taken branch overrides any stall
    always_comb begin
        stall_c    = 1'b0;
        bubble_c   = 1'b0;
        flush_c    = 1'b0;
        state_next = state;
        case (state)
            RUN: begin
                if (BranchTaken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (hazard_c) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (IdValid && Halt) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (BranchTaken) begin
                    // An older taken branch means the HALT was on the wrong path
                    flush_c    = 1'b1;
                    bubble_c   = 1'b1;
                    state_next = RUN;
                end else begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (!ex_s.v && !mem_s.v && !wb_s.v) begin
                        state_next = HALTED;
                    end
                end
            end
            HALTED: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Decode instruction moves into EX this cycle
    assign advance_c = IdValid & ~stall_c & ~flush_c & (state == RUN);

    // EX slot payload for the instruction leaving decode
    always_comb begin
        ex_next    = '0;
        ex_next.v  = advance_c & RegWrEn;
        ex_next.rd = WriteReg;
        ex_next.ld = MemRead;
    end

    // Shadow pipeline and FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            ex_s  <= '0;
            mem_s <= '0;
            wb_s  <= '0;
        end else begin
            state <= state_next;
            ex_s  <= ex_next;
            mem_s <= ex_s;
            wb_s  <= mem_s;
        end
    end

    assign Stall      = stall_c;
    assign IdExBubble = bubble_c;
    assign FlushIfId  = flush_c;
    assign Halted     = (state == HALTED);

`ifdef HAZARD_FORWARDING_EN
    logic [1:0] fwd_a_q;
    logic [1:0] fwd_b_q;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    // Operand selects: non-load EX result first, then MEM result, else regfile
    always_comb begin
        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (advance_c) begin
            if (rs_ex && !ex_s.ld) begin
                fwd_a_next = 2'b01;
            end else if (rs_mem) begin
                fwd_a_next = 2'b10;
            end
            if (rt_ex && !ex_s.ld) begin
                fwd_b_next = 2'b01;
            end else if (rt_mem) begin
                fwd_b_next = 2'b10;
            end
        end
    end

    // Selects travel with the instruction into EX; bubbles and flushes load 00
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_next;
            fwd_b_q <= fwd_b_next;
        end
    end

    assign FwdA = fwd_a_q;
    assign FwdB = fwd_b_q;
`else
    assign FwdA = 2'b00;
    assign FwdB = 2'b00;
`endif

    // Slot fields kept for completeness of the shadow pipeline but not decoded
    wire unused_slot_bits = ^{ex_s.ld, mem_s.ld, wb_s.rd, wb_s.ld};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       IdValid;
    logic [2:0] Rs;
    logic [2:0] Rt;
    logic       RsValid;
    logic       RtValid;
    logic [2:0] WriteReg;
    logic       RegWrEn;
    logic       MemRead;
    logic       Halt;
    logic       BranchTaken;
    logic       Stall;
    logic       IdExBubble;
    logic       FlushIfId;
    logic       Halted;
    logic [1:0] FwdA;
    logic [1:0] FwdB;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hazard_ctrl #(.REG_BITS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .IdValid    (IdValid),
        .Rs         (Rs),
        .Rt         (Rt),
        .RsValid    (RsValid),
        .RtValid    (RtValid),
        .WriteReg   (WriteReg),
        .RegWrEn    (RegWrEn),
        .MemRead    (MemRead),
        .Halt       (Halt),
        .BranchTaken(BranchTaken),
        .Stall      (Stall),
        .IdExBubble (IdExBubble),
        .FlushIfId  (FlushIfId),
        .Halted     (Halted),
        .FwdA       (FwdA),
        .FwdB       (FwdB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IdValid     = 1'b0;
        Rs          = 3'd0;
        Rt          = 3'd0;
        RsValid     = 1'b0;
        RtValid     = 1'b0;
        WriteReg    = 3'd0;
        RegWrEn     = 1'b0;
        MemRead     = 1'b0;
        Halt        = 1'b0;
        BranchTaken = 1'b0;
    endtask

    task automatic instr(input logic [2:0] rs, input logic [2:0] rt,
                         input logic rsv, input logic rtv,
                         input logic [2:0] wr, input logic we, input logic ld);
        idle();
        IdValid  = 1'b1;
        Rs       = rs;
        Rt       = rt;
        RsValid  = rsv;
        RtValid  = rtv;
        WriteReg = wr;
        RegWrEn  = we;
        MemRead  = ld;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_ctl(input string tag, input logic s, input logic b,
                           input logic f, input logic h);
        #1;
        chk($sformatf("%s.stall", tag),  {1'b0, Stall},      {1'b0, s});
        chk($sformatf("%s.bubble", tag), {1'b0, IdExBubble}, {1'b0, b});
        chk($sformatf("%s.flush", tag),  {1'b0, FlushIfId},  {1'b0, f});
        chk($sformatf("%s.halted", tag), {1'b0, Halted},     {1'b0, h});
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.fwda", FwdA, 2'b00);
        chk("reset.fwdb", FwdB, 2'b00);

`ifndef HAZARD_FORWARDING_EN
        // ADD r3<-r1,r2 then ADD r4<-r3,r5: two stall cycles
        instr(3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        chk_ctl("t1_prod", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        instr(3'd3, 3'd5, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        chk_ctl("t1_s1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("t1_s2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("t1_go", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t1.fwda", FwdA, 2'b00);
        chk("t1.fwdb", FwdB, 2'b00);
        // r3 consumed three instructions after its producer: no stall
        instr(3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        chk_ctl("t1_far_prod", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        instr(3'd1, 3'd2, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
        chk_ctl("t1_far_i1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        instr(3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
        chk_ctl("t1_far_i2", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        instr(3'd3, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        chk_ctl("t1_far_use", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        // JAL (writes r7) then JR r7: two stall cycles
        instr(3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0);
        chk_ctl("t4_jal", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        instr(3'd7, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        chk_ctl("t4_s1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("t4_s2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("t4_go", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
`else
        // LD r2 then ADD r6<-r2,r2: one stall, then forward from MEM/WB
        instr(3'd1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1);
        chk_ctl("t2_ld", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        instr(3'd2, 3'd2, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
        chk_ctl("t2_s1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t2_s1.fwda", FwdA, 2'b00);
        chk_ctl("t2_go", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t2.fwda", FwdA, 2'b10);
        chk("t2.fwdb", FwdB, 2'b10);
        // ADD r3 then consumer of r3 (EX) and r6 (MEM): no stall
        instr(3'd1, 3'd1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        chk_ctl("t2_alu", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        instr(3'd3, 3'd6, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        chk_ctl("t2_use", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t2_use.fwda", FwdA, 2'b01);
        chk("t2_use.fwdb", FwdB, 2'b10);
`endif
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Taken branch alongside a load-use hazard: flush wins
        instr(3'd1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1);
        chk_ctl("t3_ld", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        instr(3'd2, 3'd2, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        BranchTaken = 1'b1;
        chk_ctl("t3_br", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        // Flushed r4 writer never entered EX, so reading r4 is free
        instr(3'd4, 3'd4, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
        chk_ctl("t3_after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset during a stall aborts it
        instr(3'd1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1);
        chk_ctl("t6_ld", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        instr(3'd2, 3'd2, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
        chk_ctl("t6_stall", 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_ctl("t6_after_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // ADD r1 then HALT: three drain cycles, then sticky halt
        instr(3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        chk_ctl("t5_add", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        IdValid = 1'b1;
        Halt    = 1'b1;
        chk_ctl("t5_halt", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("t5_d1", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("t5_d2", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("t5_d3", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("t5_halted", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_ctl("t5_sticky", 1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_ctl("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_rst.fwda", FwdA, 2'b00);

        // Older taken branch while draining returns to RUN
        IdValid = 1'b1;
        Halt    = 1'b1;
        chk_ctl("dr_halt", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        BranchTaken = 1'b1;
        chk_ctl("dr_br", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        chk_ctl("dr_run", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
